// File: rtl/queue_reg.sv
// queue_reg: show-ahead register FIFO with count, full/empty and sticky overflow/underflow flags
module queue_reg #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             read,
    input  logic             clear,
    output logic [15:0]      data_out,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             push, pop;
    // A full queue still takes a push when the same edge frees a slot
    always_comb begin
        pop      = read && !empty;
        push     = load && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        ovf_d    = ovf_q || (load && full && !read);
        udf_d    = udf_q || (read && empty);
    end
    // Storage is never reset; the pointers alone define which entries are valid
    always_ff @(posedge sysclk) begin
        if (push && !clear && !sysreset) mem_q[wr_ptr_q] <= data_in;
    end
    // Control state: reset beats clear, clear beats traffic
    always_ff @(posedge sysclk) begin
        if (sysreset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end
    assign empty     = count_q == '0;
    assign full      = count_q == CW'(DEPTH);
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    assign data_out  = empty ? 16'h0000 : 16'(mem_q[rd_ptr_q]);
endmodule

// File: tb/tb_queue_reg.sv
// tb_queue_reg: randomized and directed scoreboard bench for queue_reg against a queue-based model
module tb_queue_reg;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          sysclk = 1'b0;
    logic          sysreset, load, read, clear;
    logic [W-1:0]  data_in;
    logic [15:0]   data_out;
    logic [CW-1:0] count;
    logic          empty, full, overflow, underflow;

    typedef struct {
        int cyc;
        int cnt;
        bit emp;
        bit ful;
        bit ovf;
        bit udf;
        int dout;
    } exp_t;

    exp_t sb[$];
    int   mq[$];
    bit   movf, mudf;
    int   n_edges = 0;
    int   checks  = 0;
    int   fails   = 0;

    queue_reg #(.WIDTH(W), .DEPTH(D)) dut (
        .sysclk(sysclk), .sysreset(sysreset), .data_in(data_in), .load(load),
        .read(read), .clear(clear), .data_out(data_out), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) n_edges++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: compare every settled post-edge state against the oldest prediction
    exp_t e_mon;
    always @(negedge sysclk) begin
        while (sb.size() > 0 && sb[0].cyc < n_edges) begin
            e_mon = sb.pop_front();
            chk("count",     32'(count),     32'(e_mon.cnt));
            chk("empty",     32'(empty),     32'(e_mon.emp));
            chk("full",      32'(full),      32'(e_mon.ful));
            chk("overflow",  32'(overflow),  32'(e_mon.ovf));
            chk("underflow", 32'(underflow), 32'(e_mon.udf));
            chk("data_out",  32'(data_out),  32'(e_mon.dout));
        end
    end

    // Drive one cycle, advance the model and queue the expected post-edge state
    task automatic step(bit rst, bit clr, bit ld, bit rd, logic [W-1:0] din);
        exp_t e;
        bit   was_full, was_empty, do_pop, do_push;
        sysreset = rst;
        clear    = clr;
        load     = ld;
        read     = rd;
        data_in  = din;
        if (rst || clr) begin
            mq.delete();
            movf = 0;
            mudf = 0;
        end else begin
            was_full  = mq.size() == D;
            was_empty = mq.size() == 0;
            do_pop    = rd && !was_empty;
            do_push   = ld && (!was_full || do_pop);
            if (ld && was_full && !rd) movf = 1;
            if (rd && was_empty) mudf = 1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(int'(din));
        end
        e.cyc  = n_edges;
        e.cnt  = mq.size();
        e.emp  = mq.size() == 0;
        e.ful  = mq.size() == D;
        e.ovf  = movf;
        e.udf  = mudf;
        e.dout = mq.size() > 0 ? mq[0] : 0;
        sb.push_back(e);
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sysreset = 1'b0; clear = 1'b0; load = 1'b0; read = 1'b0; data_in = '0;
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // two pushes then drain
        step(0, 0, 1, 0, 8'hA1);
        step(0, 0, 1, 0, 8'hB2);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // overfill then drain in order
        for (int i = 1; i <= 5; i++) step(0, 0, 1, 0, W'(i));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        // full with simultaneous push and pop
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, W'($urandom));
        step(0, 0, 1, 1, 8'h55);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        // empty with simultaneous pop and push
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 8'h3C);
        // streaming through the wrap point
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 8'h10);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1, W'(8'h20 + i));
        step(0, 0, 0, 1, 0);
        // clear with flags set and a concurrent load
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, W'(8'h70 + i));
        step(0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 8'hEE);
        // reset in the middle of a push burst; outputs hold until the edge
        step(0, 0, 1, 0, 8'h91);
        step(0, 0, 1, 0, 8'h92);
        sysreset = 1'b1;
        #1;
        chk("rst_hold_count", 32'(count), 32'(mq.size()));
        chk("rst_hold_data",  32'(data_out), 32'(mq[0]));
        step(1, 0, 1, 1, 8'h93);
        step(0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, W'($urandom));
        step(0, 0, 0, 0, 0);
        @(negedge sysclk);
        @(negedge sysclk);
        chk("scoreboard_drained", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
